// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder: rebuilds 12-digit 14-segment scan frames into an ASCII read buffer.
// Optional STABLE_FILTER_EN: publish only after two identical consecutive complete frames.
module seg14_scan_decoder #(
  parameter int         NDIG     = 12,
  parameter int         SEGW     = 14,
  parameter logic [7:0] UNK_CHAR = 8'h3F
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NDIG-1:0] sel,
  input  logic [SEGW-1:0] segm,
  input  logic [3:0]      rd_addr,
  output logic [7:0]      rd_char,
  output logic            frame_valid,
  output logic [7:0]      frame_cnt,
  output logic            sel_err,
  output logic            seq_err,
  output logic            unk_err
);
  localparam int AW = $clog2(NDIG);
  localparam logic [NDIG-1:0][7:0] BLANK = {NDIG{8'h20}};

  typedef enum logic {HUNT, CAPT} state_t;

  state_t               state;
  logic [NDIG-1:0]      sel_q;
  logic [SEGW-1:0]      segm_q;
  logic [AW-1:0]        idx, exp_idx;
  logic [NDIG-1:0][7:0] cap_q, pub_q, cap_nxt;
  logic [7:0]           ch;
  logic                 hit, any, multi, last, complete, publish;
`ifdef STABLE_FILTER_EN
  logic [NDIG-1:0][7:0] cmp_q;
  logic                 cmp_vld;
`endif

  // stage 2: one-hot -> index, pattern -> ASCII
  always_comb begin
    idx = '0;
    for (int k = 0; k < NDIG; k++)
      if (sel_q[k]) idx = AW'(k);
  end

  assign any   = |sel_q;
  assign multi = |(sel_q & (sel_q - NDIG'(1)));
  assign last  = (idx == AW'(NDIG-1));

  always_comb begin
    ch  = UNK_CHAR;
    hit = 1'b1;
    case (segm_q)
      14'b11101111000000: ch = 8'h41;
      14'b10011110000000: ch = 8'h45;
      14'b10010000010010: ch = 8'h49;
      14'b00011100000000: ch = 8'h4C;
      14'b11111100000100: ch = 8'h51;
      14'b10110111000000: ch = 8'h53;
      14'b10000000010010: ch = 8'h54;
      14'b01111100000000: ch = 8'h55;
      14'b00001100001001: ch = 8'h56;
      14'b00000000000000: ch = 8'h20;
      default:            hit = 1'b0;
    endcase
  end

  always_comb begin
    cap_nxt      = cap_q;
    cap_nxt[idx] = ch;
  end

  assign complete = any && !multi && (state == CAPT) && (idx == exp_idx) && last;
`ifdef STABLE_FILTER_EN
  assign publish = complete && cmp_vld && (cap_nxt == cmp_q);
`else
  assign publish = complete;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      segm_q      <= '0;
      state       <= HUNT;
      exp_idx     <= '0;
      cap_q       <= BLANK;
      pub_q       <= BLANK;
      frame_cnt   <= '0;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
      seq_err     <= 1'b0;
      unk_err     <= 1'b0;
`ifdef STABLE_FILTER_EN
      cmp_q       <= BLANK;
      cmp_vld     <= 1'b0;
`endif
    end else begin
      sel_q       <= sel;
      segm_q      <= segm;
      sel_err     <= any & multi;
      unk_err     <= any & ~multi & ~hit;
      seq_err     <= 1'b0;
      frame_valid <= publish;
      if (publish) begin
        pub_q     <= cap_nxt;
        frame_cnt <= frame_cnt + 8'd1;
      end
`ifdef STABLE_FILTER_EN
      if (complete) begin
        cmp_q   <= cap_nxt;
        cmp_vld <= 1'b1;
      end
`endif
      if (multi) state <= HUNT;
      else if (any) begin
        case (state)
          HUNT: if (idx == '0) begin
            cap_q   <= cap_nxt;
            exp_idx <= AW'(1);
            state   <= CAPT;
          end
          CAPT: begin
            if (idx == exp_idx) begin
              cap_q   <= cap_nxt;
              exp_idx <= exp_idx + 1'b1;
              if (last) state <= HUNT;
            end else if (idx == exp_idx - 1'b1) begin
              // digit held across several scan cycles
              cap_q <= cap_nxt;
            end else begin
              seq_err <= 1'b1;
              if (idx == '0) begin
                cap_q   <= cap_nxt;
                exp_idx <= AW'(1);
              end else state <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign rd_char = (32'(rd_addr) < NDIG) ? pub_q[rd_addr] : 8'h00;
endmodule

// File: tb/tb_seg14_scan_decoder.sv
// tb_seg14_scan_decoder: directed + random scans, spec-level model feeding a scoreboard.
module tb_seg14_scan_decoder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [11:0] sel = '0;
  logic [13:0] segm = '0;
  logic [3:0]  rd_addr = '0;
  logic [7:0]  rd_char, frame_cnt;
  logic        frame_valid, sel_err, seq_err, unk_err;

  seg14_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .segm(segm), .rd_addr(rd_addr),
    .rd_char(rd_char), .frame_valid(frame_valid), .frame_cnt(frame_cnt),
    .sel_err(sel_err), .seq_err(seq_err), .unk_err(unk_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef logic [11:0][7:0] frame_t;
  typedef struct { int cyc; logic [2:0] flags; } err_rec_t;
  typedef struct { int cyc; frame_t frame; logic [7:0] cnt; } frm_rec_t;
  localparam frame_t BLANK = {12{8'h20}};

  logic [13:0] pat_tab [10] = '{14'b11101111000000, 14'b10011110000000, 14'b10010000010010,
                                14'b00011100000000, 14'b11111100000100, 14'b10110111000000,
                                14'b10000000010010, 14'b01111100000000, 14'b00001100001001,
                                14'b00000000000000};
  logic [7:0]  chr_tab [10] = '{8'h41, 8'h45, 8'h49, 8'h4C, 8'h51, 8'h53, 8'h54, 8'h55, 8'h56, 8'h20};

  err_rec_t err_q [$];
  frm_rec_t frm_q [$];
  int checks = 0, errors = 0;
  bit done = 0;

  // reference model: pos = next digit expected, -1 while waiting for digit 0
  int         pos = -1;
  frame_t     cap = BLANK, prev = BLANK;
  bit         prev_ok = 0;
  logic [7:0] m_cnt = '0;

  function automatic void model_reset();
    pos = -1; cap = BLANK; prev = BLANK; prev_ok = 0; m_cnt = '0;
    err_q.delete(); frm_q.delete();
  endfunction

  function automatic void model_step(input logic [11:0] s, input logic [13:0] p, input int c);
    int d; logic [7:0] ch; bit se, qe, ue, fin;
    err_rec_t er; frm_rec_t fr;
    se = 0; qe = 0; ue = 0; fin = 0; d = 0;
    if (s == 0) return;
    if ($countones(s) > 1) begin
      se = 1; pos = -1;
    end else begin
      for (int i = 0; i < 12; i++) if (s[i]) d = i;
      ch = 8'h3F; ue = 1;
      for (int i = 0; i < 10; i++) if (pat_tab[i] == p) begin ch = chr_tab[i]; ue = 0; end
      if (pos < 0) begin
        if (d == 0) begin cap[0] = ch; pos = 1; end
      end else if (d == pos) begin
        cap[d] = ch; pos++;
        if (d == 11) begin fin = 1; pos = -1; end
      end else if (d == pos - 1) cap[d] = ch;
      else begin
        qe = 1;
        if (d == 0) begin cap[0] = ch; pos = 1; end else pos = -1;
      end
    end
    if (se | qe | ue) begin er.cyc = c + 2; er.flags = {se, qe, ue}; err_q.push_back(er); end
    if (fin) begin
`ifdef STABLE_FILTER_EN
      if (prev_ok && prev == cap) begin
        m_cnt++; fr.cyc = c + 2; fr.frame = cap; fr.cnt = m_cnt; frm_q.push_back(fr);
      end
      prev = cap; prev_ok = 1;
`else
      m_cnt++; fr.cyc = c + 2; fr.frame = cap; fr.cnt = m_cnt; frm_q.push_back(fr);
`endif
    end
  endfunction

  function automatic logic [13:0] enc(input logic [7:0] c);
    enc = 14'b11111111000000;
    for (int i = 0; i < 10; i++) if (chr_tab[i] == c) enc = pat_tab[i];
  endfunction

  task automatic drive(input logic [11:0] s, input logic [13:0] p, input int a = -1);
    sel = s; segm = p;
    rd_addr = (a < 0) ? 4'($urandom_range(15)) : 4'(a);
    model_step(s, p, cyc);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit sweep = 0);
    for (int i = 0; i < n; i++) drive(12'd0, 14'd0, sweep ? i % 16 : -1);
  endtask

  task automatic scan(input frame_t f, input int skip_d = -1, input int multi_d = -1, input int unk_d = -1);
    logic [11:0] s;
    for (int d = 0; d < 12; d++) begin
      if (d == skip_d) continue;
      s = 12'(1) << d;
      if (d == multi_d) s = s | 12'b1;
      drive(s, (d == unk_d) ? 14'b11111111000000 : enc(f[d]));
    end
  endtask

  task automatic do_reset();
    idle(3);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // stimulus
  initial begin
    frame_t base, f;
    logic [11:0] s;
    logic [13:0] p;
    int k;
    base = 96'h54_53_41_20_4C_45_56_49_55_51_53_45;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    scan(base);
    idle(16, 1);
    for (int n = 0; n < 255; n++) scan(base);
    idle(16, 1);
    scan(base, 5);
    scan(base);
    scan(base);
    idle(2);
    scan(base, -1, 1);
    scan(base);
    scan(base, -1, -1, 3);
    scan(base, -1, -1, 3);
    idle(16, 1);
    for (int d = 0; d < 7; d++) drive(12'(1) << d, enc(base[d]));
    do_reset();
    for (int d = 7; d < 12; d++) drive(12'(1) << d, enc(base[d]));
    idle(16, 1);
    scan(base);
    scan(base);
    f = base;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(1) == 1)
        for (int d = 0; d < 12; d++) f[d] = chr_tab[$urandom_range(9)];
      for (int d = 0; d < 12; d++) begin
        k = $urandom_range(99);
        s = 12'(1) << d;
        p = enc(f[d]);
        if (k < 4) continue;
        if (k < 8) s = s | (12'(1) << $urandom_range(11));
        else if (k < 12) p = 14'($urandom);
        else if (k < 18) drive(12'd0, p);
        else if (k < 24) drive(s, p);
        drive(s, p);
      end
    end
    idle(4);
    done = 1;
  end

  // monitor / scoreboard
  initial begin
    frame_t     cur_pub;
    logic [7:0] cur_cnt, exp_c;
    logic [2:0] exp_e;
    bit         exp_f;
    frm_rec_t   r;
    err_rec_t   e;
    cur_pub = BLANK;
    cur_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_pulses", {frame_valid, sel_err, seq_err, unk_err}, 4'b0);
        check("reset_frame_cnt", frame_cnt, 8'h00);
        cur_pub = BLANK;
        cur_cnt = '0;
      end else begin
        exp_e = '0;
        if (err_q.size() > 0 && err_q[0].cyc == cyc) begin e = err_q.pop_front(); exp_e = e.flags; end
        check("sel_seq_unk_err", {sel_err, seq_err, unk_err}, exp_e);
        exp_f = (frm_q.size() > 0 && frm_q[0].cyc == cyc);
        check("frame_valid", frame_valid, exp_f);
        if (exp_f) begin
          r = frm_q.pop_front();
          cur_pub = r.frame;
          cur_cnt = r.cnt;
        end
        check("frame_cnt", frame_cnt, cur_cnt);
      end
      exp_c = (rd_addr < 4'd12) ? cur_pub[rd_addr] : 8'h00;
      check("rd_char", rd_char, exp_c);
      if (done) break;
    end
    check("err_queue_drained", err_q.size(), 0);
    check("frame_queue_drained", frm_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
